// File: rtl/sdram_rr_arbiter.sv
// Round-robin arbiter sharing one sys_sdram valid/ready port between NUM_REQ requesters.
// Grant is held until the downstream handshake completes, then priority rotates.
//
// state | meaning
// IDLE  | no grant; pick next valid requester after the rotating pointer
// BUSY  | requester gi owns sys_sdram until handshake or it drops req_valid
module sdram_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  input  logic [NUM_REQ*DW-1:0]   req_wdata,
  input  logic [NUM_REQ*DW/8-1:0] req_wstrb,
  output logic [DW-1:0]           req_rdata,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [AW-1:0]           m_addr,
  output logic [DW-1:0]           m_wdata,
  output logic [DW/8-1:0]         m_wstrb,
  input  logic [DW-1:0]           m_rdata,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = DW / 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [IW-1:0]      gi;
  logic [IW-1:0]      gi_nxt;
  logic [IW-1:0]      last;
  logic [IW-1:0]      last_nxt;
  logic [IW-1:0]      scan_idx;
  logic [IW-1:0]      pick_idx;
  logic               pick_found;
  logic               sel_valid;

  // Scan last+1, last+2, ... so the most recently served requester is checked last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = IW'((int'(last) + k) % NUM_REQ);
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign sel_valid = req_valid[gi];
  assign busy      = (state == BUSY);

  always_comb begin
    m_valid   = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    req_rdata = '0;
    req_ready = '0;
    if (state == BUSY) begin
      m_valid   = sel_valid;
      m_addr    = req_addr[int'(gi)*AW +: AW];
      m_wdata   = req_wdata[int'(gi)*DW +: DW];
      m_wstrb   = req_wstrb[int'(gi)*SW +: SW];
      req_rdata = m_rdata;
      req_ready = grant & {NUM_REQ{sel_valid & m_ready}};
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    gi_nxt    = gi;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = BUSY;
          gi_nxt    = pick_idx;
          grant_nxt = NUM_REQ'(1) << pick_idx;
        end
      end
      BUSY: begin
        // A dropped request also advances the pointer so the dropper cannot starve others.
        if (!sel_valid || m_ready) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          last_nxt  = gi;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      gi    <= '0;
      last  <= IW'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      gi    <= gi_nxt;
      last  <= last_nxt;
    end
  end

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Bench for sdram_rr_arbiter: directed scenarios plus randomized traffic, checked by a
// queue scoreboard and a cycle-level reference model running in a separate monitor.
module tb_sdram_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } txn_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*SW-1:0] req_wstrb = '0;
  logic [DW-1:0]   req_rdata;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [SW-1:0]   m_wstrb;
  logic [DW-1:0]   m_rdata = 32'hA5A5_5A5A;
  logic [N-1:0]    grant;
  logic            busy;

  int   n_total = 0;
  int   n_pass  = 0;
  txn_t exp_q [N][$];
  int   rd_ptr [N];

  sdram_rr_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .req_rdata (req_rdata),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_rdata   (m_rdata),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(int i, logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s);
    txn_t t;
    req_valid[i]            = 1'b1;
    req_addr[i*AW +: AW]    = a;
    req_wdata[i*DW +: DW]   = d;
    req_wstrb[i*SW +: SW]   = s;
    t.addr  = a;
    t.wdata = d;
    t.wstrb = s;
    exp_q[i].push_back(t);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    sample();
    step();
    rst = 1'b0;
  endtask

  // Serve every outstanding request with an always-ready sys_sdram, bounded.
  task automatic drain(input logic [N-1:0] rr_in);
    logic [N-1:0] rr;
    int           n;
    rr = rr_in;
    n  = 0;
    do begin
      step();
      m_ready = 1'b1;
      for (int i = 0; i < N; i++) if (rr[i]) req_valid[i] = 1'b0;
      sample();
      rr = req_ready;
      n++;
    end while (((req_valid & ~rr) != '0) && n < 64);
    step();
    for (int i = 0; i < N; i++) if (rr[i]) req_valid[i] = 1'b0;
    chk("drain_done", 128'(req_valid), 128'(0));
  endtask

  // Monitor: reference model of grant ownership plus scoreboard pop on each handshake.
  initial begin
    bit           mb;
    int           mgi;
    int           mlast;
    bit           found;
    logic [N-1:0] eg;
    logic         ev;
    logic         ehs;
    txn_t         t;
    mb    = 1'b0;
    mgi   = 0;
    mlast = N - 1;
    for (int i = 0; i < N; i++) rd_ptr[i] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_grant", 128'(grant), 128'(0));
        chk("rst_ctrl", 128'({busy, m_valid, req_ready}), 128'(0));
        chk("rst_mfields", 128'({m_addr, m_wdata, m_wstrb}), 128'(0));
        chk("rst_rdata", 128'(req_rdata), 128'(0));
        if (mb) rd_ptr[mgi]++;
        mb    = 1'b0;
        mlast = N - 1;
      end else begin
        eg  = mb ? (N'(1) << mgi) : '0;
        ev  = mb && req_valid[mgi];
        ehs = ev && m_ready;
        chk("grant", 128'(grant), 128'(eg));
        chk("busy", 128'(busy), 128'(mb));
        chk("m_valid", 128'(m_valid), 128'(ev));
        chk("req_ready", 128'(req_ready), 128'(ehs ? eg : '0));
        if (mb)
          chk("m_fields", 128'({m_addr, m_wdata, m_wstrb}),
              128'({req_addr[mgi*AW +: AW], req_wdata[mgi*DW +: DW], req_wstrb[mgi*SW +: SW]}));
        else
          chk("idle_m_fields", 128'({m_addr, m_wdata, m_wstrb}), 128'(0));
        if (ehs) begin
          if (rd_ptr[mgi] < exp_q[mgi].size()) begin
            t = exp_q[mgi][rd_ptr[mgi]];
            chk("sb_txn", 128'({m_addr, m_wdata, m_wstrb}), 128'(t));
            chk("sb_rdata", 128'(req_rdata), 128'(m_rdata));
          end else begin
            chk("sb_underflow", 128'(rd_ptr[mgi]), 128'(exp_q[mgi].size()));
          end
          rd_ptr[mgi]++;
        end
        if (!mb) begin
          found = 1'b0;
          for (int j = 1; j <= N; j++) begin
            if (!found && req_valid[(mlast + j) % N]) begin
              found = 1'b1;
              mgi   = (mlast + j) % N;
            end
          end
          mb = found;
        end else if (!req_valid[mgi] || m_ready) begin
          if (!req_valid[mgi]) rd_ptr[mgi]++;
          mb    = 1'b0;
          mlast = mgi;
        end
      end
    end
  end

  initial begin
    logic [N-1:0] rr;
    int           waitc [N];
    logic [N-1:0] seq [9];
    seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // single write requester, sys_sdram answers 3 cycles after m_valid
    step(); set_req(2, 32'h40, 32'hDEADBEEF, 4'hF);
    sample(); chk("t1_arb_cycle", 128'(grant), 128'(0));
    step(); sample(); chk("t1_grant", 128'(grant), 128'(4'b0100));
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin step(); sample(); end
      chk("t1_m_valid", 128'(m_valid), 128'(1));
      chk("t1_m_addr", 128'(m_addr), 128'(32'h40));
      chk("t1_m_wdata", 128'(m_wdata), 128'(32'hDEADBEEF));
      chk("t1_no_ready", 128'(req_ready), 128'(0));
    end
    step(); m_ready = 1'b1; sample(); chk("t1_ready", 128'(req_ready), 128'(4'b0100));
    step(); req_valid[2] = 1'b0; m_ready = 1'b0;
    sample(); chk("t1_grant_clear", 128'(grant), 128'(0));

    // full contention from a fresh pointer
    do_reset();
    step(); m_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 32'h100 + i*16, $urandom, 4'hF);
    rr = '0;
    for (int k = 0; k < 9; k++) begin
      step();
      for (int i = 0; i < N; i++) if (rr[i]) set_req(i, 32'h200 + k*16 + i, $urandom, 4'h3);
      sample();
      chk("t2_grant_seq", 128'(grant), 128'(seq[k]));
      rr = req_ready;
    end
    drain(rr);

    // pointer rotation after serving requester 1
    step(); set_req(1, 32'h300, 32'h1111_1111, 4'hF);
    sample();
    step(); sample(); chk("t3_first", 128'(grant), 128'(4'b0010));
    chk("t3_first_done", 128'(req_ready), 128'(4'b0010));
    step(); req_valid[1] = 1'b0; sample();
    step(); set_req(0, 32'h310, 32'h2222_2222, 4'hF); set_req(1, 32'h320, 32'h3333_3333, 4'h1);
    sample(); chk("t3_arb", 128'(grant), 128'(0));
    step(); sample(); chk("t3_rot_first", 128'(grant), 128'(4'b0001));
    step(); req_valid[0] = 1'b0; sample();
    step(); sample(); chk("t3_rot_second", 128'(grant), 128'(4'b0010));
    rr = req_ready;
    drain(rr);

    // read by requester 3
    step(); m_ready = 1'b0; set_req(3, 32'h80, 32'h0, 4'h0); sample();
    step(); sample(); chk("t4_grant", 128'(grant), 128'(4'b1000));
    chk("t4_wait", 128'(req_ready), 128'(0));
    step(); m_ready = 1'b1; m_rdata = 32'h1234_5678;
    sample(); chk("t4_rdata", 128'(req_rdata), 128'(32'h1234_5678));
    chk("t4_ready", 128'(req_ready), 128'(4'b1000));
    step(); req_valid[3] = 1'b0; m_ready = 1'b0; m_rdata = 32'hA5A5_5A5A; sample();

    // stall on requester 1, then asynchronous reset mid-cycle
    step(); set_req(1, 32'h500, 32'h5555_AAAA, 4'hF); sample();
    step(); set_req(0, 32'h600, 32'h6666_6666, 4'hC);
    sample(); chk("t5_grant", 128'(grant), 128'(4'b0010));
    for (int k = 0; k < 10; k++) begin
      step(); sample();
      chk("t5_hold_grant", 128'(grant), 128'(4'b0010));
      chk("t5_hold_valid", 128'(m_valid), 128'(1));
    end
    step(); #2 rst = 1'b1; #1;
    chk("t5_async_grant", 128'(grant), 128'(0));
    chk("t5_async_ctrl", 128'({busy, m_valid, req_ready}), 128'(0));
    req_valid[1] = 1'b0;
    sample();
    step(); rst = 1'b0;
    sample(); chk("t5_post_arb", 128'(grant), 128'(0));
    step(); sample(); chk("t5_post_grant", 128'(grant), 128'(4'b0001));
    step(); m_ready = 1'b1; sample(); chk("t5_done", 128'(req_ready), 128'(4'b0001));
    step(); req_valid[0] = 1'b0; m_ready = 1'b0; sample();

    // requester 2 drops its request while granted, requester 3 waiting
    step(); set_req(2, 32'h700, 32'h7777_7777, 4'hF); sample();
    step(); set_req(3, 32'h800, 32'h8888_8888, 4'hF);
    sample(); chk("t6_grant", 128'(grant), 128'(4'b0100));
    step(); req_valid[2] = 1'b0;
    sample(); chk("t6_drop_valid", 128'(m_valid), 128'(0));
    chk("t6_drop_busy", 128'(busy), 128'(1));
    step(); sample(); chk("t6_idle", 128'({busy, grant}), 128'(0));
    step(); sample(); chk("t6_next", 128'(grant), 128'(4'b1000));
    step(); m_ready = 1'b1; sample(); chk("t6_done", 128'(req_ready), 128'(4'b1000));
    step(); req_valid[3] = 1'b0; m_ready = 1'b0; sample();

    // randomized traffic with random sys_sdram readiness and a fairness bound
    rr = '0;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (rr[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, $urandom, $urandom, SW'($urandom));
      end
      m_ready = ($urandom_range(0, 1) == 1);
      m_rdata = $urandom;
      sample();
      rr = req_ready;
      for (int i = 0; i < N; i++) begin
        if (rr[i]) begin
          chk("fair_wait", 128'(waitc[i] <= N - 1), 128'(1));
          waitc[i] = 0;
        end else if (req_valid[i] && rr != '0) begin
          waitc[i]++;
        end
      end
    end
    drain(rr);
    step(); sample();

    for (int i = 0; i < N; i++) chk("sb_drained", 128'(rd_ptr[i]), 128'(exp_q[i].size()));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
